uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares one uart_tx serializer between NUM_REQ byte producers, for example core debug printf, bootloader echo and a DMA log channel.
- Uses round-robin arbitration over a valid/ready handshake per requester.
- Sequences uart_tx: pulses start with the byte, waits for busy to rise, then waits for busy to fall before issuing the next grant.
- Sits between the SoC-side producers and the uart_tx instance, which runs on the same clock and reset.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ACK_TIMEOUT, 8, cycles to wait for tx_busy to rise after tx_start before flagging an error.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  requester i has a byte pending.
- req_data  in  NUM_REQ*8  flattened bytes; requester i uses bits [8i+7:8i].
- req_ready  out  NUM_REQ  one-hot; byte i is accepted on the edge where valid[i] and ready[i] are both high.
- grant_id  out  $clog2(NUM_REQ)  index of the last accepted requester.
- tx_start  out  1  one-cycle start pulse to uart_tx.
- tx_data  out  8  byte to uart_tx; stable from the start pulse until the frame completes.
- tx_busy  in  1  uart_tx busy.
- ctrl_busy  out  1  high in every state except IDLE.
- ack_err  out  1  one-cycle pulse when tx_busy fails to rise within ACK_TIMEOUT cycles.

Behaviour:
- Reset values (asynchronous, active-high): state=IDLE, rr_ptr=0, tx_start=0, tx_data=0, grant_id=0, ack_err=0, timeout counter=0; req_ready=0 and ctrl_busy=0 follow from IDLE.
- States: IDLE, START, WAIT_ACK, WAIT_DONE.
- IDLE:
  - req_ready is combinational: req_ready[i] = (state==IDLE) & !tx_busy & winner_onehot[i] & req_valid[i].
  - The winner is the first valid requester at or after rr_ptr, searching upward and wrapping modulo NUM_REQ.
  - On acceptance: latch tx_data=req_data[winner], grant_id=winner, rr_ptr=(winner+1) mod NUM_REQ, then go to START.
  - If no requester is valid, or tx_busy=1, stay in IDLE; rr_ptr is unchanged.
- START:
  - tx_start=1 for exactly this one cycle; clear the timeout counter; go to WAIT_ACK.
- WAIT_ACK:
  - If tx_busy=1, go to WAIT_DONE.
  - Otherwise increment the counter; when the counter reaches ACK_TIMEOUT-1 with tx_busy still 0, pulse ack_err for one cycle and go to IDLE. The byte is dropped and rr_ptr is not rewound.
- WAIT_DONE:
  - Go to IDLE on the first cycle tx_busy=0.
  - The earliest next acceptance is the cycle after that.
- Latency: the acceptance edge is followed by tx_start high in the next cycle, so there is 1 cycle from handshake to start.
- Back-to-back frames: at least 2 idle clk cycles between busy falling and the next tx_start (IDLE accept cycle, then START).
- Fairness: with all requesters continuously valid, grants rotate 0,1,...,NUM_REQ-1,0,... and no requester waits more than NUM_REQ-1 frames.
- Requester contract:
  - req_valid must hold with req_data stable until req_ready.
  - Dropping valid before ready is legal; that request is simply not seen.
  - req_valid changes in states other than IDLE are ignored.
- tx_data holds its value outside frames; it changes only on acceptance.
- Reset mid-frame: the arbiter returns to IDLE immediately; the in-flight byte is lost and no ack_err is raised. uart_tx shares the reset line.
- tx_busy=1 while IDLE (for example external use after reset): no grant is issued until it clears.
- Simultaneous new valids: only the winner is readied; the others stay pending without loss.

Decomposition:
- Package uart_pkg:
  - typedef enum logic [1:0] arb_state_t {IDLE, START, WAIT_ACK, WAIT_DONE}.
  - localparam BYTE_W=8.
  - Function rr_next(ptr, n) for the modulo increment.
- Sub-module rr_arbiter #(N):
  - Inputs: req vector, ptr.
  - Outputs: one-hot grant, grant index, any_req.
  - Purely combinational priority rotate. uart_tx_arbiter holds the FSM, pointer, latches and timeout counter.

Test Plan:
- Bench setup: NUM_REQ=4, uart_tx with TICKS_PER_BIT=87, 50 MHz clock.
- Single requester: req 2 sends 8'hA5 → req_ready[2] pulses once, tx_start 1 cycle later, tx_data=8'hA5, grant_id=2, and the tx line carries start bit, 10100101 LSB-first, then stop bit over 870 cycles; ctrl_busy drops on the cycle after busy falls.
- Full contention: all 4 valid with 8'h10, 8'h21, 8'h32, 8'h43 and each re-asserted after its ready → serial order 0,1,2,3,0 with grant_id matching; no tx_start while tx_busy=1; gap between busy falling and the next start is exactly 2 cycles.
- Wrap and skip: rr_ptr=3, only req 1 and req 3 valid → req 3 is granted first, then req 1; rr_ptr ends at 2.
- Ack timeout: stub tx_busy stuck at 0 → ack_err pulses exactly 8 cycles after tx_start, FSM returns to IDLE, and the next request is granted normally.
- Reset mid-frame: assert reset 400 cycles into a frame → all outputs immediately reach their reset values, including req_ready=0 and ctrl_busy=0; after release, pending req 0 with 8'hFF is granted first (rr_ptr=0) and the frame completes.
- Edge patterns: random 200 bytes from random requesters plus 8'h00, 8'hFF, 8'h55, 8'hAA, 8'h7E and 8'h81 → a scoreboard of accepted bytes matches the decoded tx stream in order, with no loss and no duplication.

Source files
------------

// File: rtl/uart_tx_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared types and helpers for the UART transmit arbiter.
//   arb_state_t : arbiter sequencing states
//   BYTE_W      : width of one transmitted byte
//   rr_next()   : modulo-n increment used to advance the round-robin pointer
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT_ACK,
    WAIT_DONE
  } arb_state_t;

  // Advance a round-robin pointer by one, wrapping back to zero at n.
  function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
    return (ptr + 32'd1 >= n) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational rotating-priority arbiter. Searches upward from ptr,
// wrapping modulo N, and picks the first requester with req set.
// Ports:
//   req       in  N      request vector
//   ptr       in  IDX_W  index that currently holds highest priority
//   grant     out N      one-hot winner (all zero when nothing requests)
//   grant_idx out IDX_W  binary index of the winner (0 when nothing requests)
//   any_req   out 1      at least one request is present
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any_req
);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] idx;
  logic             found;

  // Walk the requesters starting at ptr. The extra sum bit lets ptr+k exceed
  // N-1 before the wrap is folded back, which keeps non-power-of-two N correct.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_req   = |req;
    found     = 1'b0;
    sum       = '0;
    idx       = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(N)) begin
        sum = sum - (IDX_W+1)'(N);
      end
      idx = sum[IDX_W-1:0];
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
// Shares a single uart_tx serializer between NUM_REQ byte producers using
// round-robin arbitration over a valid/ready handshake per requester. After a
// byte is accepted the arbiter pulses tx_start, waits for tx_busy to rise and
// then fall before it will accept another byte. If tx_busy never rises within
// ACK_TIMEOUT cycles the byte is dropped and ack_err pulses.
// Ports:
//   clk        in  1            system clock
//   reset      in  1            asynchronous active-high reset
//   req_valid  in  NUM_REQ      requester i has a byte pending
//   req_data   in  NUM_REQ*8    requester i drives bits [8i+7:8i]
//   req_ready  out NUM_REQ      one-hot accept strobe (combinational)
//   grant_id   out clog2(N)     index of the last accepted requester
//   tx_start   out 1            one-cycle start pulse to uart_tx
//   tx_data    out 8            byte to uart_tx, held until the next accept
//   tx_busy    in  1            uart_tx busy
//   ctrl_busy  out 1            arbiter is not idle
//   ack_err    out 1            one-cycle pulse when tx_busy fails to rise
// -----------------------------------------------------------------------------
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int ACK_TIMEOUT = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*BYTE_W-1:0]     req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          tx_start,
  output logic [BYTE_W-1:0]             tx_data,
  input  logic                          tx_busy,
  output logic                          ctrl_busy,
  output logic                          ack_err
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;

  arb_state_t       state, state_nxt;
  logic [IDX_W-1:0] rr_ptr, rr_ptr_nxt;
  logic [IDX_W-1:0] grant_id_nxt;
  logic [BYTE_W-1:0] tx_data_nxt;
  logic             tx_start_nxt;
  logic             ack_err_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;

  logic [NUM_REQ-1:0] win_onehot;
  logic [IDX_W-1:0]   win_idx;
  logic               any_req;
  logic               accept;

  logic [BYTE_W-1:0] req_bytes [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign req_bytes[g] = req_data[g*BYTE_W +: BYTE_W];
  end

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .grant     (win_onehot),
    .grant_idx (win_idx),
    .any_req   (any_req)
  );

  assign accept    = (state == IDLE) && !tx_busy && any_req;
  assign ctrl_busy = (state != IDLE);

  // Ready is gated by reset as well, so a requester holding valid across a
  // reset never sees a ready strobe while the arbiter is being cleared.
  assign req_ready = ((state == IDLE) && !tx_busy && !reset) ? win_onehot : '0;

  // Next-state and registered-output logic. tx_start is registered on the
  // accept edge so it is high for exactly the START cycle; ack_err is
  // registered on the timeout edge so it is high for the first IDLE cycle.
  always_comb begin
    state_nxt    = state;
    rr_ptr_nxt   = rr_ptr;
    grant_id_nxt = grant_id;
    tx_data_nxt  = tx_data;
    tx_start_nxt = 1'b0;
    ack_err_nxt  = 1'b0;
    cnt_nxt      = cnt;
    cnt_inc      = cnt + CNT_W'(1);
    case (state)
      IDLE: begin
        if (accept) begin
          tx_data_nxt  = req_bytes[win_idx];
          grant_id_nxt = win_idx;
          rr_ptr_nxt   = IDX_W'(rr_next(32'(win_idx), NUM_REQ));
          tx_start_nxt = 1'b1;
          state_nxt    = START;
        end
      end
      START: begin
        cnt_nxt   = '0;
        state_nxt = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (tx_busy) begin
          state_nxt = WAIT_DONE;
        end else if (cnt_inc == CNT_W'(ACK_TIMEOUT - 1)) begin
          // The byte is abandoned; the pointer already moved past it.
          ack_err_nxt = 1'b1;
          cnt_nxt     = '0;
          state_nxt   = IDLE;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State, pointer, latched byte and timeout counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      grant_id <= '0;
      tx_data  <= '0;
      tx_start <= 1'b0;
      ack_err  <= 1'b0;
      cnt      <= '0;
    end else begin
      state    <= state_nxt;
      rr_ptr   <= rr_ptr_nxt;
      grant_id <= grant_id_nxt;
      tx_data  <= tx_data_nxt;
      tx_start <= tx_start_nxt;
      ack_err  <= ack_err_nxt;
      cnt      <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Directed bench for uart_tx_arbiter with NUM_REQ=4 and a behavioural uart_tx
// stand-in whose busy window is 10 bit-times of tpb clocks. busy_mode selects
// the stand-in (0), tx_busy stuck low (1) or tx_busy stuck high (2).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic [1:0]  grant_id;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic        ctrl_busy;
  logic        ack_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int bad_start = 0;
  int ack_seen = 0;

  int tpb = 87;
  int busy_mode = 0;
  logic m_busy;
  int m_cnt;
  logic [7:0] rx_q [$];

  uart_tx_arbiter #(.NUM_REQ(4), .ACK_TIMEOUT(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .grant_id  (grant_id),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .tx_busy   (tx_busy),
    .ctrl_busy (ctrl_busy),
    .ack_err   (ack_err)
  );

  // 50 MHz clock
  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural uart_tx: busy rises the cycle after start and stays high for
  // ten bit periods; every started byte is logged in rx_q.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy <= 1'b0;
      m_cnt  <= 0;
    end else if (busy_mode == 0) begin
      if (!m_busy && tx_start) begin
        m_busy <= 1'b1;
        m_cnt  <= 10 * tpb - 1;
        rx_q.push_back(tx_data);
      end else if (m_busy) begin
        if (m_cnt == 0) m_busy <= 1'b0;
        else            m_cnt  <= m_cnt - 1;
      end
    end
  end

  assign tx_busy = (busy_mode == 1) ? 1'b0 : (busy_mode == 2) ? 1'b1 : m_busy;

  always @(negedge clk) begin
    if (tx_start && tx_busy) bad_start <= bad_start + 1;
    if (ack_err) ack_seen <= ack_seen + 1;
  end

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int idx, input logic [7:0] data, input logic v);
    req_valid[idx] = v;
    req_data[idx*8 +: 8] = data;
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Polls (just after each falling edge) until some requester is readied.
  task automatic waitReady(input int max, output int idx, output bit ok);
    ok  = 1'b0;
    idx = -1;
    for (int n = 0; n < max; n++) begin
      #1;
      if (req_ready != 4'b0) begin
        ok = 1'b1;
        for (int i = 0; i < 4; i++) if (req_ready[i]) idx = i;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Waits for tx_busy to rise then fall; ends on the first busy-low cycle.
  task automatic waitFrame(input string tag, output int fall_cyc);
    int n;
    n = 0;
    while (!tx_busy && n < 20) begin step(); n++; end
    if (!tx_busy) checkOutput({tag, "_rise_timeout"}, 32'd0, 32'd1);
    n = 0;
    while (tx_busy && n < 2000) begin step(); n++; end
    if (tx_busy) checkOutput({tag, "_fall_timeout"}, 32'd1, 32'd0);
    fall_cyc = cyc;
  endtask

  logic [7:0] edges [6];
  logic [7:0] cont  [4];
  logic [7:0] rbytes [4][256];
  int rcnt [4];
  int rpos [4];
  bit pend [4];
  logic [7:0] exp_q [$];

  initial begin
    int idx, fall, start_c, n, rx_base, ack_base;
    bit ok, done;

    reset     = 1'b1;
    req_valid = '0;
    req_data  = '0;
    step();
    step();

    // Reset values
    checkOutput("rst_tx_start",  32'(tx_start),  32'd0);
    checkOutput("rst_tx_data",   32'(tx_data),   32'd0);
    checkOutput("rst_grant_id",  32'(grant_id),  32'd0);
    checkOutput("rst_ack_err",   32'(ack_err),   32'd0);
    checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
    checkOutput("rst_ctrl_busy", 32'(ctrl_busy), 32'd0);
    reset = 1'b0;
    step();

    // Single requester 2 sends A5
    $display("[TB] single requester");
    rx_base = rx_q.size();
    applyStimulus(2, 8'hA5, 1'b1);
    waitReady(5, idx, ok);
    checkOutput("t1_ready_seen", 32'(ok), 32'd1);
    checkOutput("t1_ready_vec", 32'(req_ready), 32'h4);
    step();
    checkOutput("t1_tx_start", 32'(tx_start), 32'd1);
    checkOutput("t1_tx_data", 32'(tx_data), 32'hA5);
    checkOutput("t1_grant_id", 32'(grant_id), 32'd2);
    checkOutput("t1_ready_off", 32'(req_ready), 32'd0);
    applyStimulus(2, 8'hA5, 1'b0);
    step();
    checkOutput("t1_start_pulse", 32'(tx_start), 32'd0);
    n = 0;
    while (tx_busy && n < 2000) begin n++; step(); end
    checkOutput("t1_busy_len", 32'(n), 32'd870);
    checkOutput("t1_ctrl_busy_fall", 32'(ctrl_busy), 32'd1);
    step();
    checkOutput("t1_ctrl_busy_idle", 32'(ctrl_busy), 32'd0);
    checkOutput("t1_tx_data_hold", 32'(tx_data), 32'hA5);
    checkOutput("t1_rx_count", 32'(rx_q.size() - rx_base), 32'd1);
    if (rx_q.size() > rx_base) checkOutput("t1_rx_byte", 32'(rx_q[rx_base]), 32'hA5);

    // Full contention from a fresh pointer
    $display("[TB] full contention");
    reset = 1'b1;
    step();
    reset = 1'b0;
    cont[0] = 8'h10; cont[1] = 8'h21; cont[2] = 8'h32; cont[3] = 8'h43;
    for (int i = 0; i < 4; i++) applyStimulus(i, cont[i], 1'b1);
    fall = 0;
    for (int k = 0; k < 5; k++) begin
      waitReady(3000, idx, ok);
      checkOutput("t2_ready_seen", 32'(ok), 32'd1);
      checkOutput("t2_order", 32'(idx), 32'(k % 4));
      step();
      start_c = cyc;
      checkOutput("t2_grant_id", 32'(grant_id), 32'(k % 4));
      checkOutput("t2_tx_data", 32'(tx_data), 32'(cont[k % 4]));
      if (k > 0) checkOutput("t2_gap", 32'(start_c - fall), 32'd2);
      if (k == 4) req_valid = '0;
      waitFrame("t2", fall);
    end

    // Wrap and skip: move pointer to 3, then offer requesters 1 and 3
    $display("[TB] wrap and skip");
    tpb = 8;
    applyStimulus(2, 8'h5A, 1'b1);
    waitReady(10, idx, ok);
    checkOutput("t3_pre_idx", 32'(idx), 32'd2);
    step();
    applyStimulus(2, 8'h5A, 1'b0);
    waitFrame("t3a", fall);
    applyStimulus(1, 8'h11, 1'b1);
    applyStimulus(3, 8'h33, 1'b1);
    waitReady(10, idx, ok);
    checkOutput("t3_first_vec", 32'(req_ready), 32'h8);
    step();
    checkOutput("t3_first_gid", 32'(grant_id), 32'd3);
    applyStimulus(3, 8'h33, 1'b0);
    waitFrame("t3b", fall);
    waitReady(10, idx, ok);
    checkOutput("t3_second_idx", 32'(idx), 32'd1);
    step();
    checkOutput("t3_second_gid", 32'(grant_id), 32'd1);
    checkOutput("t3_second_data", 32'(tx_data), 32'h11);
    applyStimulus(1, 8'h11, 1'b0);
    waitFrame("t3c", fall);
    for (int i = 0; i < 4; i++) applyStimulus(i, cont[i], 1'b1);
    waitReady(10, idx, ok);
    checkOutput("t3_ptr_after", 32'(idx), 32'd2);
    step();
    req_valid = '0;
    waitFrame("t3d", fall);

    // Ack timeout with tx_busy stuck low
    $display("[TB] ack timeout");
    step();
    busy_mode = 1;
    applyStimulus(0, 8'h42, 1'b1);
    waitReady(10, idx, ok);
    checkOutput("t4_idx", 32'(idx), 32'd0);
    step();
    checkOutput("t4_tx_start", 32'(tx_start), 32'd1);
    applyStimulus(0, 8'h42, 1'b0);
    n = 0;
    while (!ack_err && n < 30) begin step(); n++; end
    checkOutput("t4_ack_delay", 32'(n), 32'd8);
    checkOutput("t4_idle_at_err", 32'(ctrl_busy), 32'd0);
    step();
    checkOutput("t4_ack_pulse", 32'(ack_err), 32'd0);
    busy_mode = 0;
    applyStimulus(1, 8'h99, 1'b1);
    waitReady(10, idx, ok);
    checkOutput("t4_next_idx", 32'(idx), 32'd1);
    step();
    checkOutput("t4_next_data", 32'(tx_data), 32'h99);
    applyStimulus(1, 8'h99, 1'b0);
    waitFrame("t4", fall);

    // tx_busy held high while idle blocks any grant
    step();
    busy_mode = 2;
    applyStimulus(3, 8'h77, 1'b1);
    for (int i = 0; i < 5; i++) step();
    checkOutput("t4b_no_ready", 32'(req_ready), 32'd0);
    checkOutput("t4b_idle", 32'(ctrl_busy), 32'd0);
    busy_mode = 0;
    waitReady(10, idx, ok);
    checkOutput("t4b_idx", 32'(idx), 32'd3);
    step();
    applyStimulus(3, 8'h77, 1'b0);
    waitFrame("t4b", fall);

    // Reset in the middle of a frame
    $display("[TB] reset mid-frame");
    tpb = 87;
    step();
    applyStimulus(2, 8'h3C, 1'b1);
    waitReady(10, idx, ok);
    step();
    applyStimulus(2, 8'h3C, 1'b0);
    applyStimulus(0, 8'hFF, 1'b1);
    for (int i = 0; i < 400; i++) step();
    checkOutput("t5_mid_frame", 32'(ctrl_busy), 32'd1);
    ack_base = ack_seen;
    reset = 1'b1;
    #1;
    checkOutput("t5_req_ready", 32'(req_ready), 32'd0);
    checkOutput("t5_ctrl_busy", 32'(ctrl_busy), 32'd0);
    checkOutput("t5_tx_start", 32'(tx_start), 32'd0);
    checkOutput("t5_tx_data", 32'(tx_data), 32'd0);
    checkOutput("t5_grant_id", 32'(grant_id), 32'd0);
    checkOutput("t5_ack_err", 32'(ack_err), 32'd0);
    step();
    reset = 1'b0;
    waitReady(10, idx, ok);
    checkOutput("t5_idx", 32'(idx), 32'd0);
    step();
    checkOutput("t5_grant_id_after", 32'(grant_id), 32'd0);
    checkOutput("t5_tx_data_after", 32'(tx_data), 32'hFF);
    applyStimulus(0, 8'hFF, 1'b0);
    waitFrame("t5", fall);
    checkOutput("t5_no_ack_err", 32'(ack_seen - ack_base), 32'd0);

    // Edge and random bytes from random requesters against a scoreboard
    $display("[TB] random stream");
    tpb = 4;
    step();
    rx_base = rx_q.size();
    edges[0] = 8'h00; edges[1] = 8'hFF; edges[2] = 8'h55;
    edges[3] = 8'hAA; edges[4] = 8'h7E; edges[5] = 8'h81;
    for (int i = 0; i < 4; i++) begin rcnt[i] = 0; rpos[i] = 0; pend[i] = 1'b0; end
    for (int j = 0; j < 206; j++) begin
      int r;
      logic [7:0] b;
      b = (j < 6) ? edges[j] : 8'($urandom);
      r = $urandom_range(0, 3);
      rbytes[r][rcnt[r]] = b;
      rcnt[r]++;
    end
    for (int i = 0; i < 4; i++) if (rcnt[i] > 0) applyStimulus(i, rbytes[i][0], 1'b1);
    done = 1'b0;
    for (int n2 = 0; n2 < 206 * 60 + 2000 && !done; n2++) begin
      for (int i = 0; i < 4; i++) begin
        if (pend[i]) begin
          pend[i] = 1'b0;
          rpos[i]++;
          if (rpos[i] < rcnt[i]) applyStimulus(i, rbytes[i][rpos[i]], 1'b1);
          else                   applyStimulus(i, 8'h00, 1'b0);
        end
      end
      #1;
      for (int i = 0; i < 4; i++) begin
        if (req_ready[i]) begin
          exp_q.push_back(rbytes[i][rpos[i]]);
          pend[i] = 1'b1;
        end
      end
      done = !ctrl_busy && !tx_busy;
      for (int i = 0; i < 4; i++) if (rpos[i] < rcnt[i] || pend[i]) done = 1'b0;
      if (!done) step();
    end
    checkOutput("t6_completed", 32'(done), 32'd1);
    checkOutput("t6_accepted", 32'(exp_q.size()), 32'd206);
    checkOutput("t6_sent", 32'(rx_q.size() - rx_base), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && rx_base + i < rx_q.size(); i++)
      checkOutput($sformatf("t6_byte%0d", i), 32'(rx_q[rx_base + i]), 32'(exp_q[i]));

    checkOutput("start_while_busy", 32'(bad_start), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
